conv3x3_engine: RTL and testbench

CONV3X3_ENGINE -- requirements
Module: conv3x3_engine

---
 rtl/conv3x3_engine.sv | 199 +++++++++++++++++++
 tb/tb_conv3x3_engine.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_engine.sv
// 3x3 convolution engine with a serially loaded signed kernel.
//
// A kernel of nine signed coefficients is shifted in on k_data/k_valid after a
// k_start pulse. Once all nine are held, each enable_mult cycle presents one
// unsigned 3x3 pixel window (w1..w9, row-major). The windows are multiplied,
// summed through a three-stage pipeline and emitted on out_data/out_valid, with
// row_end/frame_end marking the last valid output of a row/frame.
//
// Ports:
//   clk, resetn                   clock (rising edge), asynchronous active-low reset
//   w1..w9                        unsigned pixel window
//   enable_mult                   window valid this cycle (used in RUN only)
//   k_start, k_valid, k_data      kernel load control and signed coefficient
//   kernel_ready                  high while in RUN
//   out_data, out_valid           signed result and its qualifier
//   row_end, frame_end            last-output-of-row / last-output-of-frame flags
module conv3x3_engine #(
    parameter int  DATA_WIDTH = 8,
    parameter int  IMG_WIDTH  = 4,
    parameter int  IMG_HEIGHT = 4,
    parameter int  RELU       = 1,
    localparam int ACC_WIDTH  = 2 * DATA_WIDTH + 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] w1,
    input  logic [DATA_WIDTH-1:0] w2,
    input  logic [DATA_WIDTH-1:0] w3,
    input  logic [DATA_WIDTH-1:0] w4,
    input  logic [DATA_WIDTH-1:0] w5,
    input  logic [DATA_WIDTH-1:0] w6,
    input  logic [DATA_WIDTH-1:0] w7,
    input  logic [DATA_WIDTH-1:0] w8,
    input  logic [DATA_WIDTH-1:0] w9,
    input  logic                  enable_mult,
    input  logic                  k_start,
    input  logic                  k_valid,
    input  logic [DATA_WIDTH-1:0] k_data,
    output logic                  kernel_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    output logic                  row_end,
    output logic                  frame_end
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH + 1;
    localparam int SUM_WIDTH  = PROD_WIDTH + 2;
    localparam int COL_W      = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W      = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [COL_W-1:0] COL_ISSUE_MAX = COL_W'(IMG_WIDTH - 3);
    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_HEIGHT - 3);

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0]        pix     [9];
    logic signed [DATA_WIDTH-1:0] coef_q  [9];
    logic [3:0]                   idx_q;
    logic [COL_W-1:0]             col_q;
    logic [ROW_W-1:0]             row_q;

    logic load_fire, run_fire, issue, last_col, col_wrap, row_last;

    logic signed [PROD_WIDTH-1:0] prod_d [9];
    logic signed [PROD_WIDTH-1:0] prod_q [9];
    logic signed [SUM_WIDTH-1:0]  sum_d  [3];
    logic signed [SUM_WIDTH-1:0]  sum_q  [3];
    logic signed [ACC_WIDTH-1:0]  total_d;

    logic v1_q, re1_q, fe1_q;
    logic v2_q, re2_q, fe2_q;

    always_comb begin
        pix[0] = w1; pix[1] = w2; pix[2] = w3;
        pix[3] = w4; pix[4] = w5; pix[5] = w6;
        pix[6] = w7; pix[7] = w8; pix[8] = w9;
    end

    // k_start overrides every other input, in every state.
    always_comb begin
        state_d = state_q;
        if (k_start) begin
            state_d = StLoad;
        end else begin
            case (state_q)
                StLoad:  if (k_valid && idx_q == 4'd8) state_d = StRun;
                default: ;
            endcase
        end
    end

    assign load_fire = !k_start && (state_q == StLoad) && k_valid;
    assign run_fire  = !k_start && (state_q == StRun) && enable_mult;
    assign last_col  = (col_q == COL_ISSUE_MAX);
    assign col_wrap  = (col_q == COL_LAST);
    assign row_last  = (row_q == ROW_LAST);
    // The two rightmost columns straddle a row boundary, so they are counted only.
    assign issue     = run_fire && (col_q <= COL_ISSUE_MAX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            kernel_ready <= 1'b0;
        end else begin
            state_q      <= state_d;
            kernel_ready <= (state_d == StRun);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 9; i++) coef_q[i] <= '0;
            idx_q <= '0;
            col_q <= '0;
            row_q <= '0;
        end else if (k_start) begin
            idx_q <= '0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            if (load_fire) begin
                for (int i = 0; i < 9; i++) begin
                    if (idx_q == 4'(i)) coef_q[i] <= k_data;
                end
                idx_q <= idx_q + 4'd1;
            end
            if (run_fire) begin
                if (col_wrap) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
        end
    end

    // Pixels are zero-extended so they stay non-negative in signed arithmetic.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            prod_d[i] = $signed({{(DATA_WIDTH + 1){1'b0}}, pix[i]})
                      * $signed({{(DATA_WIDTH + 1){coef_q[i][DATA_WIDTH-1]}}, coef_q[i]});
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            sum_d[r] = {{2{prod_q[3*r][PROD_WIDTH-1]}}, prod_q[3*r]}
                     + {{2{prod_q[3*r+1][PROD_WIDTH-1]}}, prod_q[3*r+1]}
                     + {{2{prod_q[3*r+2][PROD_WIDTH-1]}}, prod_q[3*r+2]};
        end
        total_d = {sum_q[0][SUM_WIDTH-1], sum_q[0]}
                + {sum_q[1][SUM_WIDTH-1], sum_q[1]}
                + {sum_q[2][SUM_WIDTH-1], sum_q[2]};
        if (RELU != 0 && total_d[ACC_WIDTH-1]) total_d = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 9; i++) prod_q[i] <= '0;
            for (int r = 0; r < 3; r++) sum_q[r] <= '0;
            v1_q      <= 1'b0; re1_q <= 1'b0; fe1_q <= 1'b0;
            v2_q      <= 1'b0; re2_q <= 1'b0; fe2_q <= 1'b0;
            out_valid <= 1'b0;
            row_end   <= 1'b0;
            frame_end <= 1'b0;
            out_data  <= '0;
        end else begin
            if (k_start) begin
                v1_q      <= 1'b0; re1_q <= 1'b0; fe1_q <= 1'b0;
                v2_q      <= 1'b0; re2_q <= 1'b0; fe2_q <= 1'b0;
                out_valid <= 1'b0;
                row_end   <= 1'b0;
                frame_end <= 1'b0;
            end else begin
                v1_q      <= issue;
                re1_q     <= issue && last_col;
                fe1_q     <= issue && last_col && row_last;
                v2_q      <= v1_q;
                re2_q     <= re1_q;
                fe2_q     <= fe1_q;
                out_valid <= v2_q;
                row_end   <= re2_q;
                frame_end <= fe2_q;
            end
            if (issue) begin
                for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
            end
            if (v1_q) begin
                for (int r = 0; r < 3; r++) sum_q[r] <= sum_d[r];
            end
            if (v2_q && !k_start) out_data <= total_d;
        end
    end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Self-checking bench for conv3x3_engine. Two instances share all inputs: one
// with RELU=0 and one with RELU=1. A behavioural model queues the expected
// result of every issued window; a negedge monitor pops and compares outputs.
module tb_conv3x3_engine;

    localparam int DW = 8;
    localparam int IW = 4;
    localparam int IH = 4;
    localparam int AW = 2 * DW + 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic [DW-1:0] pix [9];
    logic          enable_mult, k_start, k_valid;
    logic [DW-1:0] k_data;

    logic          kr0, ov0, re0, fe0;
    logic [AW-1:0] od0;
    logic          kr1, ov1, re1, fe1;
    logic [AW-1:0] od1;

    always #5 clk = ~clk;

    conv3x3_engine #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .RELU(0)) dut (
        .clk(clk), .resetn(resetn),
        .w1(pix[0]), .w2(pix[1]), .w3(pix[2]), .w4(pix[3]), .w5(pix[4]),
        .w6(pix[5]), .w7(pix[6]), .w8(pix[7]), .w9(pix[8]),
        .enable_mult(enable_mult), .k_start(k_start), .k_valid(k_valid), .k_data(k_data),
        .kernel_ready(kr0), .out_data(od0), .out_valid(ov0), .row_end(re0), .frame_end(fe0)
    );

    conv3x3_engine #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .RELU(1)) dut_relu (
        .clk(clk), .resetn(resetn),
        .w1(pix[0]), .w2(pix[1]), .w3(pix[2]), .w4(pix[3]), .w5(pix[4]),
        .w6(pix[5]), .w7(pix[6]), .w8(pix[7]), .w9(pix[8]),
        .enable_mult(enable_mult), .k_start(k_start), .k_valid(k_valid), .k_data(k_data),
        .kernel_ready(kr1), .out_data(od1), .out_valid(ov1), .row_end(re1), .frame_end(fe1)
    );

    typedef struct {
        int data_raw;
        int data_relu;
        bit re;
        bit fe;
        int due;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_out   = 0;
    int   n_re    = 0;
    int   n_fe    = 0;

    // Reference model state: mode 0=idle, 1=load, 2=run.
    int kc [9];
    int kern [9];
    int mode = 0;
    int idx  = 0;
    int col  = 0;
    int row  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of control inputs (pixels already set), update the model,
    // and return at the following negedge with controls deasserted.
    task automatic drive_cycle(input bit ks, input bit kv, input int kd, input bit en);
        int   s;
        exp_t e;
        k_start     = ks;
        k_valid     = kv;
        k_data      = kd[DW-1:0];
        enable_mult = en;
        if (ks) begin
            mode = 1; idx = 0; col = 0; row = 0;
            for (int j = sb.size() - 1; j >= 0; j--) if (sb[j].due > cyc) sb.delete(j);
        end else if (mode == 1 && kv) begin
            kc[idx] = int'($signed(kd[DW-1:0]));
            idx++;
            if (idx == 9) mode = 2;
        end else if (mode == 2 && en) begin
            if (col <= IW - 3) begin
                s = 0;
                for (int i = 0; i < 9; i++) s += int'(pix[i]) * kc[i];
                e.data_raw  = s;
                e.data_relu = (s < 0) ? 0 : s;
                e.re        = (col == IW - 3);
                e.fe        = (col == IW - 3) && (row == IH - 3);
                e.due       = cyc + 3;
                sb.push_back(e);
            end
            if (col == IW - 1) begin
                col = 0;
                row = (row == IH - 3) ? 0 : row + 1;
            end else begin
                col++;
            end
        end
        @(negedge clk);
        k_start = 1'b0; k_valid = 1'b0; enable_mult = 1'b0;
    endtask

    task automatic load_kern();
        drive_cycle(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 9; i++) drive_cycle(1'b0, 1'b1, kern[i], 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rand_pix();
        for (int i = 0; i < 9; i++) pix[i] = DW'($urandom_range(0, 255));
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (ov0 || ov1) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", ov0 | ov1, 0);
                end else begin
                    e = sb.pop_front();
                    n_out++;
                    if (re0) n_re++;
                    if (fe0) n_fe++;
                    check("valid_relu0", ov0, 1);
                    check("valid_relu1", ov1, 1);
                    check("latency", cyc, e.due);
                    check("data_raw", $signed(od0), e.data_raw);
                    check("data_relu", $signed(od1), e.data_relu);
                    check("row_end", re0, e.re);
                    check("frame_end", fe0, e.fe);
                    check("row_end_relu", re1, e.re);
                    check("frame_end_relu", fe1, e.fe);
                end
            end else begin
                check("flags_without_valid", re0 | fe0 | re1 | fe1, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base_out, base_re, base_fe;
        resetn = 1'b0; enable_mult = 1'b0; k_start = 1'b0; k_valid = 1'b0; k_data = '0;
        for (int i = 0; i < 9; i++) begin pix[i] = '0; kc[i] = 0; end
        idle(2);
        check("rst_kernel_ready", kr0, 0);
        check("rst_out_valid", ov0, 0);
        check("rst_out_data", od0, 0);
        check("rst_row_end", re0, 0);
        check("rst_frame_end", fe1, 0);
        resetn = 1'b1;
        idle(2);

        // All-ones kernel, window 1..9 -> 45, exactly 3 cycles later.
        for (int i = 0; i < 9; i++) kern[i] = 1;
        load_kern();
        check("kernel_ready_loaded", kr0, 1);
        for (int i = 0; i < 9; i++) pix[i] = DW'(i + 1);
        drive_cycle(1'b0, 1'b0, 0, 1'b1);
        idle(1);
        check("lat_not_early", ov0, 0);
        idle(1);
        check("lat_valid", ov0, 1);
        check("sum45", $signed(od0), 45);
        idle(1);
        check("hold_valid_low", ov0, 0);
        check("hold_data", $signed(od0), 45);
        idle(3);

        // Centre coefficient -1 with w5=5: -5 raw, 0 with ReLU but still valid.
        for (int i = 0; i < 9; i++) kern[i] = 0;
        kern[4] = -1;
        load_kern();
        rand_pix();
        pix[4] = DW'(5);
        drive_cycle(1'b0, 1'b0, 0, 1'b1);
        idle(2);
        check("neg_raw", $signed(od0), -5);
        check("neg_relu_valid", ov1, 1);
        check("neg_relu_data", $signed(od1), 0);
        idle(3);

        // Eight back-to-back windows over a 4x4 frame, then a few into the next.
        for (int i = 0; i < 9; i++) kern[i] = int'($urandom_range(0, 255)) - 128;
        load_kern();
        base_out = n_out; base_re = n_re; base_fe = n_fe;
        for (int p = 0; p < 8; p++) begin
            rand_pix();
            drive_cycle(1'b0, 1'b0, 0, 1'b1);
        end
        idle(4);
        check("frame_outputs", n_out - base_out, 4);
        check("frame_row_ends", n_re - base_re, 2);
        check("frame_frame_ends", n_fe - base_fe, 1);
        for (int p = 0; p < 3; p++) begin
            rand_pix();
            drive_cycle(1'b0, 1'b0, 0, 1'b1);
        end
        idle(5);

        // Extreme negative: 255 * -128 * 9 without wrap.
        for (int i = 0; i < 9; i++) begin kern[i] = -128; pix[i] = 8'd255; end
        load_kern();
        drive_cycle(1'b0, 1'b0, 0, 1'b1);
        idle(2);
        check("max_neg", $signed(od0), -293760);
        check("max_neg_relu", $signed(od1), 0);
        idle(3);

        // enable_mult during LOAD and k_valid during RUN are ignored.
        for (int i = 0; i < 9; i++) kern[i] = int'($urandom_range(0, 255)) - 128;
        base_out = n_out;
        drive_cycle(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, kern[i], 1'b0);
        rand_pix();
        drive_cycle(1'b0, 1'b0, 0, 1'b1);
        drive_cycle(1'b0, 1'b0, 0, 1'b1);
        for (int i = 3; i < 9; i++) drive_cycle(1'b0, 1'b1, kern[i], 1'b0);
        idle(4);
        check("no_out_during_load", n_out - base_out, 0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 77 + i, 1'b0);
        rand_pix();
        drive_cycle(1'b0, 1'b0, 0, 1'b1);
        idle(5);
        check("kernel_kept_output", n_out - base_out, 1);

        // Restart after 5 coefficients: the new kernel lands at index 0.
        drive_cycle(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 100 - i, 1'b0);
        for (int i = 0; i < 9; i++) kern[i] = i - 4;
        load_kern();
        check("restart_ready", kr0, 1);
        rand_pix();
        drive_cycle(1'b0, 1'b0, 0, 1'b1);
        idle(5);

        // Reset one cycle after enable_mult discards the in-flight result.
        rand_pix();
        drive_cycle(1'b0, 1'b0, 0, 1'b1);
        resetn = 1'b0;
        #1;
        check("arst_kernel_ready", kr0, 0);
        check("arst_out_valid", ov0, 0);
        check("arst_out_data", od0, 0);
        check("arst_row_end", re0, 0);
        check("arst_frame_end", fe0, 0);
        check("arst_relu_data", od1, 0);
        sb.delete();
        mode = 0; idx = 0; col = 0; row = 0;
        for (int i = 0; i < 9; i++) kc[i] = 0;
        base_out = n_out;
        idle(2);
        resetn = 1'b1;
        idle(5);
        drive_cycle(1'b0, 1'b0, 0, 1'b1);
        drive_cycle(1'b0, 1'b1, 9, 1'b1);
        check("post_rst_idle_ready", kr0, 0);
        drive_cycle(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, 1'b1, 3 * i - 10, 1'b0);
        check("ready_after_8", kr0, 0);
        drive_cycle(1'b0, 1'b1, 13, 1'b0);
        check("ready_after_9", kr0, 1);
        idle(3);
        check("no_out_after_reset", n_out - base_out, 0);
        rand_pix();
        drive_cycle(1'b0, 1'b0, 0, 1'b1);
        idle(5);
        check("post_rst_output", n_out - base_out, 1);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
